// File: rtl/cond_issue_scheduler.sv
// Issue-stage controller: owns the committed NZCV flags, evaluates each offered
// instruction's condition field and holds flag readers while flag writers are in flight.
module cond_issue_scheduler #(
    parameter int unsigned PEND_MAX = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [31:0]      IR,
    output logic             instr_ready,
    input  logic             alu_flags_vld,
    input  logic             alu_N,
    input  logic             alu_Z,
    input  logic             alu_C,
    input  logic             alu_V,
    output logic             exec_valid,
    output logic             exec_pass,
    output logic [31:0]      exec_ir,
    output logic             N,
    output logic             Zero,
    output logic             C,
    output logic             V,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             underflow_err
);

    localparam int unsigned PEND_W = $clog2(PEND_MAX + 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t            state;
    logic [PEND_W-1:0] pend_cnt;
    logic [3:0]        cc;
    logic              needs_flags;
    logic              sets_flags;
    logic              cond_ok;
    logic              pend_zero;
    logic              pend_full;
    logic              accept;
    logic              pend_inc;

    // Condition-code evaluation against the committed flags only.
    function automatic logic cond_pass(input logic [3:0] code, input logic n, input logic z,
                                       input logic c, input logic v);
        logic res;
        res = 1'b0;
        case (code)
            4'h0:    res = z;
            4'h1:    res = !z;
            4'h2:    res = c;
            4'h3:    res = !c;
            4'h4:    res = n;
            4'h5:    res = !n;
            4'h6:    res = v;
            4'h7:    res = !v;
            4'h8:    res = c && !z;
            4'h9:    res = !c || z;
            4'hA:    res = (n == v);
            4'hB:    res = (n != v);
            4'hC:    res = !z && (n == v);
            4'hD:    res = z || (n != v);
            4'hE:    res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Decode, issue gating and handshake.
    always_comb begin
        cc          = IR[31:28];
        needs_flags = (cc != 4'hE) && (cc != 4'hF);
        sets_flags  = (IR[27:26] == 2'b00) && IR[20];
        cond_ok     = cond_pass(cc, N, Zero, C, V);
        pend_zero   = (pend_cnt == '0);
        pend_full   = (pend_cnt == PEND_W'(PEND_MAX));
        instr_ready = !reset && !(needs_flags && !pend_zero) && !(sets_flags && pend_full);
        accept      = instr_valid && instr_ready;
        stall       = instr_valid && !instr_ready;
        pend_inc    = accept && sets_flags && cond_ok;
    end

    // State, issue register, flag register and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_RUN;
            pend_cnt      <= '0;
            exec_valid    <= 1'b0;
            exec_pass     <= 1'b0;
            exec_ir       <= '0;
            N             <= 1'b0;
            Zero          <= 1'b0;
            C             <= 1'b0;
            V             <= 1'b0;
            stall_cnt     <= '0;
            underflow_err <= 1'b0;
        end else begin
            exec_valid <= accept;
            exec_pass  <= accept && cond_ok;
            if (accept) begin
                exec_ir <= IR;
            end

            if (alu_flags_vld) begin
                N    <= alu_N;
                Zero <= alu_Z;
                C    <= alu_C;
                V    <= alu_V;
            end

            // A return with nothing pending and no same-cycle increment is an underflow.
            case ({pend_inc, alu_flags_vld})
                2'b10: pend_cnt <= pend_cnt + PEND_W'(1);
                2'b01: begin
                    if (pend_zero) begin
                        underflow_err <= 1'b1;
                    end else begin
                        pend_cnt <= pend_cnt - PEND_W'(1);
                    end
                end
                default: pend_cnt <= pend_cnt;
            endcase

            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end

            case (state)
                ST_RUN: begin
                    if (stall) begin
                        state <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (accept || !instr_valid) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_cond_issue_scheduler.sv
// Bench for cond_issue_scheduler: directed sequences, a condition-code table and
// randomized traffic checked against an abstract flag/pending-count model.
module tb_cond_issue_scheduler;

    localparam int unsigned PEND_MAX = 3;
    localparam int unsigned TB_CNT_W = 4;
    localparam int          SAT      = (1 << TB_CNT_W) - 1;

    localparam logic [31:0] ADDS = 32'hE2900001;
    localparam logic [31:0] BEQ  = 32'h0A000004;
    localparam logic [31:0] BNE  = 32'h1A000004;

    logic                clk;
    logic                reset;
    logic                instr_valid;
    logic [31:0]         IR;
    logic                instr_ready;
    logic                alu_flags_vld;
    logic                alu_N, alu_Z, alu_C, alu_V;
    logic                exec_valid;
    logic                exec_pass;
    logic [31:0]         exec_ir;
    logic                N, Zero, C, V;
    logic                stall;
    logic [TB_CNT_W-1:0] stall_cnt;
    logic                underflow_err;

    cond_issue_scheduler #(
        .PEND_MAX(PEND_MAX),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .IR           (IR),
        .instr_ready  (instr_ready),
        .alu_flags_vld(alu_flags_vld),
        .alu_N        (alu_N),
        .alu_Z        (alu_Z),
        .alu_C        (alu_C),
        .alu_V        (alu_V),
        .exec_valid   (exec_valid),
        .exec_pass    (exec_pass),
        .exec_ir      (exec_ir),
        .N            (N),
        .Zero         (Zero),
        .C            (C),
        .V            (V),
        .stall        (stall),
        .stall_cnt    (stall_cnt),
        .underflow_err(underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    int          m_pend;
    logic [3:0]  m_flags;
    logic        m_uf;
    int          m_scnt;
    logic        m_ev, m_ep;
    logic [31:0] m_eir;
    logic        obs_ready, obs_stall;

    typedef struct {
        logic [3:0] cc;
        logic [3:0] nzcv;
        logic       exp_pass;
    } vec_t;
    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ARM-style: even code is the base test, odd code is its inverse; 1111 never passes.
    function automatic logic ref_cond(input logic [3:0] code, input logic [3:0] f);
        logic n, z, c, v, base;
        {n, z, c, v} = f;
        case (code[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (code == 4'hF) return 1'b0;
        return base ^ code[0];
    endfunction

    // One clock: drive, check combinational outputs, advance model, check registered outputs.
    task automatic cycle(input logic rst, input logic v, input logic [31:0] ir,
                         input logic fv, input logic [3:0] f);
        logic needs, sets, rdy, stl, acc, cnd;
        int   inc;
        reset         = rst;
        instr_valid   = v;
        IR            = ir;
        alu_flags_vld = fv;
        {alu_N, alu_Z, alu_C, alu_V} = f;
        needs = (ir[31:28] < 4'd14);
        sets  = (ir[27:26] == 2'b00) && ir[20];
        rdy   = !rst && !(needs && m_pend != 0) && !(sets && m_pend >= int'(PEND_MAX));
        stl   = v && !rdy;
        #1;
        obs_ready = instr_ready;
        obs_stall = stall;
        chk("instr_ready", 32'(instr_ready), 32'(rdy));
        chk("stall", 32'(stall), 32'(stl));
        acc = v && rdy;
        cnd = ref_cond(ir[31:28], m_flags);
        if (rst) begin
            m_pend = 0; m_flags = 4'h0; m_uf = 1'b0; m_scnt = 0;
            m_ev = 1'b0; m_ep = 1'b0; m_eir = 32'h0;
        end else begin
            m_ev = acc;
            m_ep = acc && cnd;
            if (acc) m_eir = ir;
            inc    = (acc && sets && cnd) ? 1 : 0;
            m_pend = m_pend + inc - (fv ? 1 : 0);
            if (m_pend < 0) begin
                m_pend = 0;
                m_uf   = 1'b1;
            end
            if (fv) m_flags = f;
            if (stl && m_scnt < SAT) m_scnt++;
        end
        @(posedge clk);
        #1;
        chk("exec_valid", 32'(exec_valid), 32'(m_ev));
        chk("exec_pass", 32'(exec_pass), 32'(m_ep));
        chk("exec_ir", exec_ir, m_eir);
        chk("nzcv", 32'({N, Zero, C, V}), 32'(m_flags));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
        chk("underflow_err", 32'(underflow_err), 32'(m_uf));
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rir;
        logic        rv;
        vecs[0]  = '{4'h0, 4'b0100, 1'b1};
        vecs[1]  = '{4'h0, 4'b0000, 1'b0};
        vecs[2]  = '{4'h1, 4'b0100, 1'b0};
        vecs[3]  = '{4'h2, 4'b0010, 1'b1};
        vecs[4]  = '{4'h3, 4'b0010, 1'b0};
        vecs[5]  = '{4'h4, 4'b1000, 1'b1};
        vecs[6]  = '{4'h5, 4'b1000, 1'b0};
        vecs[7]  = '{4'h6, 4'b0001, 1'b1};
        vecs[8]  = '{4'h7, 4'b0000, 1'b1};
        vecs[9]  = '{4'h8, 4'b0010, 1'b1};
        vecs[10] = '{4'h8, 4'b0110, 1'b0};
        vecs[11] = '{4'h9, 4'b0110, 1'b1};
        vecs[12] = '{4'hA, 4'b1001, 1'b1};
        vecs[13] = '{4'hB, 4'b1000, 1'b1};
        vecs[14] = '{4'hC, 4'b0000, 1'b1};
        vecs[15] = '{4'hC, 4'b0100, 1'b0};
        vecs[16] = '{4'hD, 4'b1000, 1'b1};
        vecs[17] = '{4'hE, 4'b0000, 1'b1};
        vecs[18] = '{4'hF, 4'b1111, 1'b0};

        m_pend = 0; m_flags = 4'h0; m_uf = 1'b0; m_scnt = 0;
        m_ev = 1'b0; m_ep = 1'b0; m_eir = 32'h0;
        reset = 1'b1; instr_valid = 1'b0; IR = 32'h0; alu_flags_vld = 1'b0;
        {alu_N, alu_Z, alu_C, alu_V} = 4'h0;
        @(negedge clk);

        // 1: AL ADDS, flags returned two cycles after accept
        cycle(1, 0, 32'h0, 0, 4'h0);
        chk("t1_rst_valid", 32'(exec_valid), 32'd0);
        chk("t1_rst_nzcv", 32'({N, Zero, C, V}), 32'd0);
        cycle(0, 0, 32'h0, 0, 4'h0);
        cycle(0, 1, ADDS, 0, 4'h0);
        chk("t1_ready", 32'(obs_ready), 32'd1);
        chk("t1_exec_valid", 32'(exec_valid), 32'd1);
        chk("t1_exec_pass", 32'(exec_pass), 32'd1);
        chk("t1_exec_ir", exec_ir, ADDS);
        cycle(0, 0, 32'h0, 0, 4'h0);
        cycle(0, 0, 32'h0, 1, 4'b0100);
        chk("t1_zero", 32'(Zero), 32'd1);

        // 2: BEQ held behind an in-flight ADDS
        cycle(1, 0, 32'h0, 0, 4'h0);
        cycle(0, 1, ADDS, 0, 4'h0);
        cycle(0, 1, BEQ, 0, 4'h0);
        chk("t2_ready_held", 32'(obs_ready), 32'd0);
        chk("t2_stall", 32'(obs_stall), 32'd1);
        cycle(0, 1, BEQ, 0, 4'h0);
        cycle(0, 1, BEQ, 1, 4'b0100);
        chk("t2_ready_at_return", 32'(obs_ready), 32'd0);
        cycle(0, 1, BEQ, 0, 4'h0);
        chk("t2_ready_after", 32'(obs_ready), 32'd1);
        chk("t2_exec_pass", 32'(exec_pass), 32'd1);
        chk("t2_exec_ir", exec_ir, BEQ);
        chk("t2_stall_cnt", 32'(stall_cnt), 32'd3);
        cycle(0, 0, 32'h0, 0, 4'h0);

        // 5: flag return with nothing pending
        cycle(1, 0, 32'h0, 0, 4'h0);
        cycle(0, 0, 32'h0, 1, 4'b1011);
        chk("t5_nzcv", 32'({N, Zero, C, V}), 32'hB);
        chk("t5_underflow", 32'(underflow_err), 32'd1);
        cycle(0, 1, BEQ, 0, 4'h0);
        chk("t5_ready", 32'(obs_ready), 32'd1);
        chk("t5_pass", 32'(exec_pass), 32'd0);
        chk("t5_sticky", 32'(underflow_err), 32'd1);

        // 4: pending-count saturation and same-cycle return + issue
        cycle(1, 0, 32'h0, 0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, ADDS, 0, 4'h0);
            chk("t4_fill_ready", 32'(obs_ready), 32'd1);
        end
        cycle(0, 1, ADDS, 0, 4'h0);
        chk("t4_full_ready", 32'(obs_ready), 32'd0);
        cycle(0, 1, ADDS, 1, 4'h0);
        chk("t4_full_at_return", 32'(obs_ready), 32'd0);
        cycle(0, 1, ADDS, 0, 4'h0);
        chk("t4_after_return", 32'(obs_ready), 32'd1);
        cycle(0, 0, 32'h0, 1, 4'h0);
        cycle(0, 1, ADDS, 1, 4'h0);
        chk("t4_same_cycle", 32'(obs_ready), 32'd1);
        cycle(0, 1, ADDS, 0, 4'h0);
        chk("t4_refill", 32'(obs_ready), 32'd1);
        cycle(0, 1, ADDS, 0, 4'h0);
        chk("t4_full_again", 32'(obs_ready), 32'd0);
        chk("t4_no_underflow", 32'(underflow_err), 32'd0);
        cycle(0, 0, 32'h0, 0, 4'h0);

        // 6: reset while stalled with a stale flag return
        cycle(1, 0, 32'h0, 0, 4'h0);
        cycle(0, 1, ADDS, 0, 4'h0);
        cycle(0, 1, ADDS, 0, 4'h0);
        cycle(0, 1, BNE, 0, 4'h0);
        chk("t6_held", 32'(obs_ready), 32'd0);
        cycle(1, 1, BNE, 1, 4'b1111);
        chk("t6_valid", 32'(exec_valid), 32'd0);
        chk("t6_pass", 32'(exec_pass), 32'd0);
        chk("t6_ir", exec_ir, 32'h0);
        chk("t6_nzcv", 32'({N, Zero, C, V}), 32'd0);
        chk("t6_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("t6_underflow", 32'(underflow_err), 32'd0);
        cycle(0, 1, BNE, 0, 4'h0);
        chk("t6_ready_after", 32'(obs_ready), 32'd1);
        chk("t6_bne_pass", 32'(exec_pass), 32'd1);

        // stall counter saturation
        cycle(1, 0, 32'h0, 0, 4'h0);
        cycle(0, 1, ADDS, 0, 4'h0);
        for (int i = 0; i < 20; i++) cycle(0, 1, BEQ, 0, 4'h0);
        chk("sat_stall_cnt", 32'(stall_cnt), 32'(SAT));
        cycle(0, 0, 32'h0, 1, 4'h0);

        // 3: condition table with literal expectations, then full 16x16 sweep
        cycle(1, 0, 32'h0, 0, 4'h0);
        foreach (vecs[i]) begin
            cycle(0, 1, ADDS, 0, 4'h0);
            cycle(0, 0, 32'h0, 1, vecs[i].nzcv);
            cycle(0, 1, {vecs[i].cc, 4'hA, 24'h0}, 0, 4'h0);
            chk($sformatf("tbl_cc%0h_nzcv%0h", vecs[i].cc, vecs[i].nzcv),
                32'(exec_pass), 32'(vecs[i].exp_pass));
        end
        for (int cc = 0; cc < 16; cc++) begin
            for (int f = 0; f < 16; f++) begin
                cycle(0, 1, ADDS, 0, 4'h0);
                cycle(0, 0, 32'h0, 1, 4'(f));
                cycle(0, 1, {4'(cc), 4'hA, 24'h0}, 0, 4'h0);
            end
        end

        // randomized traffic; a stalled instruction is usually held stable
        rir = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            if (obs_stall && $urandom_range(0, 3) != 0) begin
                rv = 1'b1;
            end else begin
                rv  = ($urandom_range(0, 3) != 0);
                rir = $urandom;
                if ($urandom_range(0, 1) == 1) rir[31:28] = 4'hE;
                if ($urandom_range(0, 1) == 1) rir[27:26] = 2'b00;
            end
            cycle(($urandom_range(0, 199) == 0), rv, rir,
                  ($urandom_range(0, 3) == 0), 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
